ctrl_seq: RTL

- Parametrised, sequenced control unit for the single-cycle processor family; successor to the combinational instruction decoder.
- Decodes the fetched instruction word into register-file, ALU and data-memory controls.
- Owns the two-word BNE sequence internally through a state machine; the external read_jump input is dropped.
- Adds multi-cycle load stalls (pc_en) and a sticky halt. Sits between instruction ROM/PC and the datapath.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/ctrl_decode.sv | 98 +++++++++
 rtl/ctrl_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the sequenced control unit.
// Holds the opcode map, the sequencer state encoding and the halt encoding,
// plus a helper that sizes the load-wait counter.
package ctrl_pkg;

  // Opcode map of the single-cycle processor family (3-bit opcode field).
  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_MOV   = 3'd1,
    OP_SHIFT = 3'd2,
    OP_LW    = 3'd3,
    OP_SW    = 3'd4,
    OP_XOR   = 3'd5,
    OP_AND   = 3'd6,
    OP_BNE   = 3'd7
  } opcode_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_DECODE    = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_JADDR     = 3'd2,
    S_SKIP      = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  // Halt is encoded as a SHIFT whose register/amount bits are all zero
  // (a shift of r0 by nothing has no architectural effect, so it is reused).
  localparam opcode_e HALT_OPCODE = OP_SHIFT;

  // Load counter width. $clog2(MEM_LAT+1) collapses to zero bits for
  // single-cycle memories, so keep at least one bit to stay legal.
  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: field extraction and per-opcode base enables.
// Ports: instruction in; opcode/operand/immediate/jump fields out; base enables
// (as if in S_DECODE with a single-cycle load) plus is_halt/is_lw/is_bne flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int IW   = 9,
  parameter int OPW  = 3,
  parameter int RW   = 3,
  parameter int IMMW = 8,
  parameter int PCW  = 9
) (
  input  logic [IW-1:0]   instruction,
  output logic [OPW-1:0]  opcode,
  output logic [RW-1:0]   operand1,
  output logic [RW-1:0]   operand2,
  output logic [RW-1:0]   reg_write_addr,
  output logic [IMMW-1:0] immediate,
  output logic            func,
  output logic [PCW-1:0]  jump_addr,
  output logic            base_imm,
  output logic            base_alu,
  output logic            base_wreg,
  output logic            base_wmem,
  output logic            base_rmem,
  output logic            base_pc,
  output logic            is_halt,
  output logic            is_lw,
  output logic            is_bne
);

  logic operands_zero;

  assign opcode         = instruction[IW-1 -: OPW];
  assign operand1       = instruction[2*RW-1:RW];
  assign operand2       = instruction[RW-1:0];
  assign reg_write_addr = instruction[2*RW-1:RW];
  assign func           = instruction[RW-1];
  assign jump_addr      = PCW'(instruction);
  assign operands_zero  = (instruction[2*RW-1:0] == '0);

  always_comb begin
    immediate = '0;
    base_imm  = 1'b0;
    base_alu  = 1'b0;
    base_wreg = 1'b0;
    base_wmem = 1'b0;
    base_rmem = 1'b0;
    base_pc   = 1'b0;
    is_halt   = 1'b0;
    is_lw     = 1'b0;
    is_bne    = 1'b0;
    case (opcode)
      OPW'(OP_ADD), OPW'(OP_XOR), OPW'(OP_AND): begin
        base_alu  = 1'b1;
        base_wreg = 1'b1;
        base_pc   = 1'b1;
      end
      OPW'(OP_MOV): begin
        immediate = IMMW'(instruction[RW-1:0]);
        base_imm  = 1'b1;
        base_alu  = 1'b1;
        base_wreg = 1'b1;
        base_pc   = 1'b1;
      end
      OPW'(HALT_OPCODE): begin
        // Shift amount is one bit narrower than a register field.
        immediate = IMMW'(instruction[RW-2:0]);
        if (operands_zero) begin
          is_halt = 1'b1;
        end else begin
          base_imm  = 1'b1;
          base_alu  = 1'b1;
          base_wreg = 1'b1;
          base_pc   = 1'b1;
        end
      end
      OPW'(OP_LW): begin
        // Single-cycle form; the sequencer withholds writeback/pc when stalling.
        is_lw     = 1'b1;
        base_rmem = 1'b1;
        base_wreg = 1'b1;
        base_pc   = 1'b1;
      end
      OPW'(OP_SW): begin
        base_wmem = 1'b1;
        base_pc   = 1'b1;
      end
      OPW'(OP_BNE): begin
        is_bne  = 1'b1;
        base_pc = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Sequenced control unit: decodes the fetched word and sequences BNE, LW stalls and halt.
// Ports: Clk/Reset; instruction and branch_taken in; decoded fields plus
// datapath/memory/PC enables and a sticky halt out.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPW     = 3,
  parameter int RW      = 3,
  parameter int IMMW    = 8,
  parameter int PCW     = 9,
  parameter int MEM_LAT = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [IW-1:0]   instruction,
  input  logic            branch_taken,
  output logic [OPW-1:0]  opcode,
  output logic [RW-1:0]   operand1,
  output logic [RW-1:0]   operand2,
  output logic [RW-1:0]   reg_write_addr,
  output logic [IMMW-1:0] immediate,
  output logic            func,
  output logic [PCW-1:0]  jump_addr,
  output logic            imm_operand2,
  output logic            alu_write_reg,
  output logic            write_to_reg,
  output logic            write_mem,
  output logic            read_mem,
  output logic            jump_en,
  output logic            pc_en,
  output logic            halt
);

  localparam int CW        = cnt_width(MEM_LAT);
  localparam bit MULTI_LW  = (MEM_LAT > 0);

  // Elaboration-time parameter sanity.
  if (IW != OPW + 2 * RW) begin : g_bad_iw
    $error("ctrl_seq: IW must equal OPW+2*RW");
  end
  if (PCW < IW) begin : g_bad_pcw
    $error("ctrl_seq: PCW must be >= IW");
  end
  if (IMMW < RW) begin : g_bad_immw
    $error("ctrl_seq: IMMW must be >= RW");
  end

  state_e        state;
  logic [CW-1:0] count;

  logic base_imm, base_alu, base_wreg, base_wmem, base_rmem, base_pc;
  logic is_halt, is_lw, is_bne;

  ctrl_decode #(
    .IW   (IW),
    .OPW  (OPW),
    .RW   (RW),
    .IMMW (IMMW),
    .PCW  (PCW)
  ) u_decode (
    .instruction    (instruction),
    .opcode         (opcode),
    .operand1       (operand1),
    .operand2       (operand2),
    .reg_write_addr (reg_write_addr),
    .immediate      (immediate),
    .func           (func),
    .jump_addr      (jump_addr),
    .base_imm       (base_imm),
    .base_alu       (base_alu),
    .base_wreg      (base_wreg),
    .base_wmem      (base_wmem),
    .base_rmem      (base_rmem),
    .base_pc        (base_pc),
    .is_halt        (is_halt),
    .is_lw          (is_lw),
    .is_bne         (is_bne)
  );

  // State and load counter. The enables below are decoded from this registered
  // state together with the live instruction, because the datapath must act on
  // the fetched word in the same cycle it is presented.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_DECODE;
      count <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          if (is_halt) begin
            state <= S_HALT;
          end else if (is_lw && MULTI_LW) begin
            state <= S_LOAD_WAIT;
            count <= CW'(1);
          end else if (is_bne) begin
            state <= branch_taken ? S_JADDR : S_SKIP;
          end
        end
        S_LOAD_WAIT: begin
          if (count == CW'(MEM_LAT)) begin
            count <= '0;
            state <= S_DECODE;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_JADDR, S_SKIP: state <= S_DECODE;
        S_HALT:          state <= S_HALT;
        default:         state <= S_DECODE;
      endcase
    end
  end

  always_comb begin
    imm_operand2  = 1'b0;
    alu_write_reg = 1'b0;
    write_to_reg  = 1'b0;
    write_mem     = 1'b0;
    read_mem      = 1'b0;
    jump_en       = 1'b0;
    pc_en         = 1'b0;
    halt          = 1'b0;
    if (!Reset) begin
      case (state)
        S_DECODE: begin
          imm_operand2  = base_imm;
          alu_write_reg = base_alu;
          write_mem     = base_wmem;
          read_mem      = base_rmem;
          halt          = is_halt;
          // A stalled load holds the PC and defers writeback to its last cycle.
          write_to_reg  = base_wreg && !(is_lw && MULTI_LW);
          pc_en         = base_pc && !(is_lw && MULTI_LW);
        end
        S_LOAD_WAIT: begin
          read_mem = 1'b1;
          if (count == CW'(MEM_LAT)) begin
            write_to_reg = 1'b1;
            pc_en        = 1'b1;
          end
        end
        S_JADDR: jump_en = 1'b1;
        S_SKIP:  pc_en   = 1'b1;
        S_HALT:  halt    = 1'b1;
        default: begin
        end
      endcase
    end
  end

endmodule
